// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
// Purpose : SPI master for the SPI slave / dual-port RAM subsystem. Takes one
//           10-bit command word {type[1:0], payload[7:0]}, frames it with SS_n,
//           shifts it MSB-first on MOSI (one bit per clk) and, for rd-data
//           commands (type 11), waits RD_LAT cycles and captures an 8-bit reply
//           from MISO which is returned on rd_data with a one-cycle rd_valid.
// Params  : RD_LAT  idle cycles between last command bit and first MISO sample
//                   (0..15, default 2)
// Macro   : SPI_MASTER_ABORT_EN - when defined adds the abort input; abort in
//           START/SHIFT/WAIT/RECV forces GAP on the next cycle.
// Ports   : clk        system clock, rising edge
//           rst        asynchronous active-high reset
//           cmd_valid  command word present
//           cmd_ready  command can be accepted (IDLE only)
//           cmd_data   {type[1:0], payload[7:0]}
//           SS_n       slave select, active-low
//           MOSI       serial data to slave
//           MISO       serial data from slave
//           rd_valid   one-cycle pulse, rd_data valid
//           rd_data    byte received in a rd-data frame
//           busy       high whenever not IDLE
//           abort      (SPI_MASTER_ABORT_EN only) terminate current frame
// All outputs are registered from the next-state decode so they line up with
// the state they describe.
// -----------------------------------------------------------------------------
module spi_master_ctrl #(
  parameter int RD_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_data,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy
`ifdef SPI_MASTER_ABORT_EN
  ,
  input  logic       abort
`endif
);

  localparam logic [3:0] LAT    = 4'(RD_LAT);
  localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_SHIFT = 3'd2,
    S_WAIT  = 3'd3,
    S_RECV  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic [9:0] r_sh;
  logic [1:0] r_type;
  logic [7:0] r_rx;
  logic       w_abort;
  logic       w_hs;
  logic       w_rd_done;
  logic       w_ss_low;

`ifdef SPI_MASTER_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // cmd_ready is registered as (state == IDLE), so this matches the port.
  assign w_hs = (r_state == S_IDLE) && cmd_valid;

  // Next-state decode; w_rd_done marks a rd-data frame that finished normally.
  always_comb begin
    w_next    = r_state;
    w_rd_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) w_next = S_START;
        else           w_next = S_IDLE;
      end
      S_START: begin
        if (w_abort) w_next = S_GAP;
        else         w_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_abort) begin
          w_next = S_GAP;
        end else if (r_cnt == 4'd9) begin
          if (r_type == 2'b11) begin
            if (LAT != 4'd0) w_next = S_WAIT;
            else             w_next = S_RECV;
          end else begin
            w_next = S_GAP;
          end
        end else begin
          w_next = S_SHIFT;
        end
      end
      S_WAIT: begin
        if (w_abort)              w_next = S_GAP;
        else if (r_cnt == LAT_M1) w_next = S_RECV;
        else                      w_next = S_WAIT;
      end
      S_RECV: begin
        if (w_abort) begin
          w_next = S_GAP;
        end else if (r_cnt == 4'd7) begin
          w_next    = S_GAP;
          w_rd_done = 1'b1;
        end else begin
          w_next = S_RECV;
        end
      end
      S_GAP:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Per-state cycle counter restarts on every state change.
  always_comb begin
    if (w_next != r_state) w_cnt_nxt = 4'd0;
    else                   w_cnt_nxt = r_cnt + 4'd1;
  end

  assign w_ss_low = (w_next == S_START) || (w_next == S_SHIFT) ||
                    (w_next == S_WAIT)  || (w_next == S_RECV);

  // State register and cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Command shift register: loaded on handshake, shifted as each bit goes out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh   <= 10'd0;
      r_type <= 2'b00;
      MOSI   <= 1'b0;
    end else begin
      if (w_hs) begin
        r_sh   <= cmd_data;
        r_type <= cmd_data[9:8];
      end else if (w_next == S_SHIFT) begin
        r_sh <= {r_sh[8:0], 1'b0};
      end else begin
        r_sh <= r_sh;
      end
      // MOSI for the coming cycle is the current MSB while shifting, else 0.
      MOSI <= (w_next == S_SHIFT) ? r_sh[9] : 1'b0;
    end
  end

  // Receive path: MISO shifted in only during RECV; rd_data updated only on
  // a completed rd-data frame so an aborted frame leaves it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx     <= 8'h00;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      if (r_state == S_RECV) r_rx <= {r_rx[6:0], MISO};
      else                   r_rx <= r_rx;
      if (w_rd_done) rd_data <= {r_rx[6:0], MISO};
      else           rd_data <= rd_data;
      rd_valid <= w_rd_done;
    end
  end

  // Framing/status outputs registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SS_n      <= 1'b1;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      SS_n      <= ~w_ss_low;
      cmd_ready <= (w_next == S_IDLE);
      busy      <= (w_next != S_IDLE);
    end
  end

endmodule
